// File: rtl/kernel_cc_fifo_w32_w512_packer_if.sv
// Interfaces for the packer: FIFO read side (empty_n/read/dout) and the
// packed-beat valid/ready stream toward the write-back stage.

interface kernel_cc_fifo_w32_w512_packer_rd_if #(
  parameter int WIDTH = 32
);
  logic             if_empty_n;
  logic             if_read;
  logic [WIDTH-1:0] if_dout;

  modport master (output if_empty_n, output if_dout, input if_read);
  modport slave  (input if_empty_n, input if_dout, output if_read);
endinterface

interface kernel_cc_fifo_w32_w512_packer_out_if #(
  parameter int WIDTH = 512,
  parameter int LANES = 16
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [LANES-1:0] out_keep;
  logic             out_last;

  modport master (output out_valid, output out_data, output out_keep,
                  output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_keep,
                  input out_last, output out_ready);
endinterface

// File: rtl/kernel_cc_fifo_w32_w512_packer.sv
// Packs 32-bit words popped from the kernel_cc FIFO into 512-bit beats; a flush
// drains a partial beat with per-lane keep bits and a last flag.

module kernel_cc_fifo_w32_w512_packer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 512,  // integer multiple of IN_WIDTH
  parameter int CNT_WIDTH = 32
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  kernel_cc_fifo_w32_w512_packer_rd_if.slave          fifo,
  kernel_cc_fifo_w32_w512_packer_out_if.master        beat,
  input  logic                                        flush,
  output logic [CNT_WIDTH-1:0]                        beat_count,
  output logic                                        busy
);

  localparam int LANES = OUT_WIDTH / IN_WIDTH;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  logic [IDX_W-1:0]                 idx;
  logic [LANES-1:0][IN_WIDTH-1:0]   acc;
  logic                             flush_pending;

  logic [LANES-1:0][IN_WIDTH-1:0]   data_q;
  logic [LANES-1:0]                 keep_q;
  logic                             valid_q;
  logic                             last_q;

  logic                             at_last;
  logic                             slot_free;
  logic                             pop;
  logic                             full_beat;
  logic                             flush_load;
  logic [LANES-1:0][IN_WIDTH-1:0]   full_data;
  logic [LANES-1:0]                 flush_keep;

  assign at_last   = (idx == LAST_IDX);
  assign slot_free = ~valid_q | beat.out_ready;

  // The last lane may only be popped if the held beat can leave this cycle,
  // otherwise the completed beat would have nowhere to go.
  assign fifo.if_read = reset_n & fifo.if_empty_n & ~flush_pending
                      & ~(at_last & valid_q & ~beat.out_ready);

  assign pop        = fifo.if_read & fifo.if_empty_n;
  assign full_beat  = pop & at_last;
  assign flush_load = flush_pending & slot_free;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    full_data            = acc;
    full_data[LANES-1]   = fifo.if_dout;
    flush_keep           = '0;
    for (int k = 0; k < LANES; k++) begin
      flush_keep[k] = (k < int'(idx));
    end
  end

  // NOTE: reset is asynchronous (listed in the sensitivity list) and all state,
  // including the accumulator, is cleared so a flushed beat's unfilled lanes are
  // guaranteed zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx           <= '0;
      acc           <= '0;
      flush_pending <= 1'b0;
      data_q        <= '0;
      keep_q        <= '0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      beat_count    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (full_beat) begin
        data_q  <= full_data;
        keep_q  <= '1;
        last_q  <= 1'b0;
        valid_q <= 1'b1;
      end else if (flush_load) begin
        data_q  <= acc;
        keep_q  <= flush_keep;
        last_q  <= 1'b1;
        valid_q <= 1'b1;
      end else if (beat.out_ready) begin
        valid_q <= 1'b0;
      end

      if (valid_q && beat.out_ready) begin
        beat_count <= beat_count + 1'b1;
      end

      if (full_beat || flush_load) begin
        acc <= '0;
        idx <= '0;
      end else if (pop) begin
        acc[idx] <= fifo.if_dout;
        idx      <= idx + 1'b1;
      end

      // A pulse arriving while a flush is already pending is absorbed.
      if (flush_load) begin
        flush_pending <= 1'b0;
      end else if (flush) begin
        flush_pending <= 1'b1;
      end
    end
  end

  assign beat.out_valid = valid_q;
  assign beat.out_data  = data_q;
  assign beat.out_keep  = keep_q;
  assign beat.out_last  = last_q;

  assign busy = (idx != '0) | flush_pending | valid_q;

endmodule

// File: doc/kernel_cc_fifo_w32_w512_packer.md
Name: kernel_cc_fifo_w32_w512_packer

Overview:
- Downstream consumer of the kernel_cc 32-bit/depth-32 shift-register FIFO.
- Pops 32-bit label/vertex words through the FIFO's empty_n/read handshake and packs 16 of them into one 512-bit beat.
- Beats go out on a valid/ready stream to the memory write-back stage.
- A flush request drains a partially filled beat, marked with lane-keep bits and a last flag.

Parameters:
- IN_WIDTH, 32, FIFO word width.
- OUT_WIDTH, 512, packed beat width. Must be an integer multiple of IN_WIDTH.
- LANES, OUT_WIDTH/IN_WIDTH (16), lanes per beat. Derived; do not override.
- CNT_WIDTH, 32, width of the beat counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_empty_n  in  1  FIFO has data.
- if_read  out  1  pop request to FIFO.
- if_dout  in  IN_WIDTH  FIFO head word, valid whenever if_empty_n=1.
- flush  in  1  single-cycle flush request.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  OUT_WIDTH  packed beat; lane k occupies bits [IN_WIDTH*k +: IN_WIDTH].
- out_keep  out  LANES  per-lane valid bits.
- out_last  out  1  final beat of a flush.
- beat_count  out  CNT_WIDTH  beats accepted downstream since reset.
- busy  out  1  high when lane index != 0, a flush is pending, or out_valid=1.

Behaviour:
- Reset: reset_n=0 asynchronously clears all state:
  - if_read=0, out_valid=0, out_data=0, out_keep=0, out_last=0, beat_count=0, busy=0.
  - Lane index idx=0, accumulator=0, flush_pending=0.
- Pop rule: a word is consumed only on a cycle where if_read=1 and if_empty_n=1.
  - if_read is combinational: if_empty_n & ~flush_pending & ~(idx==LANES-1 & out_valid & ~out_ready).
  - if_read is never high while if_empty_n=0.
- Accumulate: a consumed word is written into accumulator lane idx. idx increments mod LANES.
- Beat emission on the 16th word (idx==LANES-1 consumed):
  - On that same edge, output register <= {accumulator lanes 0..14, if_dout}, with keep=all ones and last=0.
  - out_valid=1, idx=0, accumulator cleared.
  - This is legal when the output slot is empty or draining that cycle (out_valid & out_ready).
  - Latency: the 16th pop edge to out_valid=1 is 0 extra cycles (registered output visible the next cycle).
- Output handshake: a beat transfers on out_valid & out_ready.
  - After transfer, out_valid drops unless reloaded on the same edge.
  - out_data, out_keep and out_last hold stable while out_valid & ~out_ready.
  - beat_count increments on each transfer and wraps at 2^CNT_WIDTH.
- Flush:
  - A flush pulse sets flush_pending on the next edge.
  - A word consumed in the same cycle as the flush pulse is included in the flushed data.
  - flush while flush_pending=1 is ignored.
  - While flush_pending=1, no pops occur.
  - When flush_pending=1 and the output slot is empty or draining:
    - Load accumulator into the output register, with keep bit k=1 for k<idx and unfilled lanes' data=0.
    - Set last=1, idx=0, clear accumulator, clear flush_pending.
  - idx==0 at flush produces a beat with out_keep=0, out_last=1 (end-of-stream marker). It is still counted in beat_count.
- Simultaneous 16th pop and flush pulse: the full beat is emitted first with last=0. The flush then emits the keep=0, last=1 marker beat.
- Backpressure: if out_ready=0 indefinitely, the packer stops popping after filling 15 lanes plus one held beat. FIFO contents are never lost or duplicated.
- Ordering: words appear in beats in strict FIFO pop order, lane 0 first.

Test Plan:
- Reset then push 0x00000001..0x00000010 with out_ready=1:
  - Exactly 16 pops.
  - One beat with lane k = k+1, out_keep=0xFFFF, out_last=0.
  - beat_count=1.
- Push 40 words (0x100+n), then pulse flush:
  - Two full beats, then a third beat with lanes 0..7 = 0x120..0x127, lanes 8..15=0, out_keep=0x00FF, out_last=1.
  - beat_count=3, busy=0 afterwards.
- Hold out_ready=0 with 48 words queued:
  - Pops stop after 31 words.
  - out_data stays stable.
  - Release out_ready: the remaining beats arrive in order, no gaps or duplicates.
- Flush with idx=0 and empty FIFO: one beat with out_keep=0, out_last=1; beat_count increments by 1.
- Flush pulse on the same cycle as the 16th pop: full beat with last=0, then marker beat with out_keep=0, out_last=1.
- Assert reset_n=0 asynchronously mid-beat (idx=5, out_valid=1):
  - All outputs clear immediately without waiting for a clock edge.
  - After release, the next 16 pops form a fresh beat starting at lane 0.
